// File: rtl/dport_req_buffer_if.sv
// Bundles for the data-port request buffer. The core side carries requests in and
// responses out; the memory side carries the FIFO head out and slave responses in.
interface dport_core_if;
  logic [31:0] req_addr;
  logic [31:0] req_data_wr;
  logic        req_rd;
  logic [3:0]  req_wr;
  logic [10:0] req_tag;
  logic [2:0]  req_cmo;
  logic        req_accept;
  logic [31:0] resp_data;
  logic        resp_ack;
  logic        resp_error;
  logic [10:0] resp_tag;

  modport master (
    output req_addr, req_data_wr, req_rd, req_wr, req_tag, req_cmo,
    input  req_accept, resp_data, resp_ack, resp_error, resp_tag
  );

  modport slave (
    input  req_addr, req_data_wr, req_rd, req_wr, req_tag, req_cmo,
    output req_accept, resp_data, resp_ack, resp_error, resp_tag
  );
endinterface

interface dport_mem_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_wr;
  logic        mem_rd;
  logic [3:0]  mem_wr;
  logic [10:0] mem_tag;
  logic [2:0]  mem_cmo;
  logic        mem_accept;
  logic [31:0] mem_data_rd;
  logic        mem_ack;
  logic        mem_error;
  logic [10:0] mem_resp_tag;

  modport master (
    output mem_addr, mem_data_wr, mem_rd, mem_wr, mem_tag, mem_cmo,
    input  mem_accept, mem_data_rd, mem_ack, mem_error, mem_resp_tag
  );

  modport slave (
    input  mem_addr, mem_data_wr, mem_rd, mem_wr, mem_tag, mem_cmo,
    output mem_accept, mem_data_rd, mem_ack, mem_error, mem_resp_tag
  );
endinterface

// File: rtl/dport_req_buffer.sv
// Request FIFO between the core data port and a data-side slave: caps outstanding
// requests, drains them before maintenance ops, and registers responses back.
module dport_req_buffer #(
  parameter int DEPTH   = 2,
  parameter int MAX_OUT = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  dport_core_if.slave  core,
  dport_mem_if.master  mem
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rd;
    logic [3:0]  wr;
    logic [10:0] tag;
    logic [2:0]  cmo;
  } req_t;

  req_t          fifo [DEPTH];
  req_t          head;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          req_active;
  logic          push;
  logic          issue_ok;
  logic          pop;
  logic          ack_valid;

  // Pointers carry an extra wrap bit so equal low bits can mean empty or full.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = fifo[rd_ptr[AW-1:0]];
  assign req_active = core.req_rd || (|core.req_wr) || (|core.req_cmo);
  assign push       = req_active && !full;

  assign core.req_accept = !full;

  // Maintenance ops wait until every earlier request has been acknowledged.
  assign issue_ok  = !empty && (count < CW'(MAX_OUT)) && ((head.cmo == 3'b000) || (count == '0));
  assign pop       = issue_ok && mem.mem_accept;
  assign ack_valid = mem.mem_ack && ((count != '0) || pop);

  assign mem.mem_addr    = head.addr;
  assign mem.mem_data_wr = head.data;
  assign mem.mem_tag     = head.tag;
  assign mem.mem_rd      = issue_ok && head.rd;
  assign mem.mem_wr      = issue_ok ? head.wr  : 4'b0000;
  assign mem.mem_cmo     = issue_ok ? head.cmo : 3'b000;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo[i] <= '0;
      end
    end else if (push) begin
      fifo[wr_ptr[AW-1:0]] <= '{addr: core.req_addr, data: core.req_data_wr, rd: core.req_rd,
                                 wr: core.req_wr, tag: core.req_tag, cmo: core.req_cmo};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Acks arriving with nothing outstanding (e.g. for requests issued before reset) are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else begin
      case ({pop, ack_valid})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      core.resp_ack   <= 1'b0;
      core.resp_error <= 1'b0;
      core.resp_tag   <= '0;
      core.resp_data  <= '0;
    end else begin
      core.resp_ack   <= ack_valid;
      core.resp_error <= mem.mem_error;
      core.resp_tag   <= mem.mem_resp_tag;
      if (ack_valid) begin
        core.resp_data <= mem.mem_data_rd;
      end
    end
  end

endmodule

// File: tb/tb_dport_req_buffer.sv
// Randomized bench for dport_req_buffer: the driver queues accepted requests, and a
// separate monitor checks issue order, outstanding cap, drain-before-CMO and responses.
module tb_dport_req_buffer;

  localparam int DEPTH   = 2;
  localparam int MAX_OUT = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rd;
    logic [3:0]  wr;
    logic [10:0] tag;
    logic [2:0]  cmo;
    longint      born;
  } req_t;

  logic   clk_i  = 1'b0;
  logic   rst_ni = 1'b0;
  longint cyc    = 0;
  int     checks = 0;
  int     errors = 0;
  int     model_out = 0;
  req_t   req_q[$];

  dport_core_if core ();
  dport_mem_if  mem ();

  dport_req_buffer #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .core  (core),
    .mem   (mem)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge, the accept handshake is judged 2ns later.
  task automatic apply_stimulus(input bit do_req, input int acc_pct, input int ack_pct,
                                input int cmo_pct, input int spur_pct);
    req_t r;
    int   kind;
    @(negedge clk_i);
    r.addr = $urandom;
    r.data = $urandom;
    r.tag  = 11'($urandom);
    r.rd   = 1'b0;
    r.wr   = 4'b0000;
    r.cmo  = 3'b000;
    r.born = 0;
    if (do_req) begin
      kind = int'($urandom_range(0, 99));
      if (kind < cmo_pct)  r.cmo = 3'b001 << $urandom_range(0, 2);
      else if (kind % 2)   r.rd  = 1'b1;
      else                 r.wr  = 4'($urandom_range(1, 15));
    end
    core.req_addr    = r.addr;
    core.req_data_wr = r.data;
    core.req_rd      = r.rd;
    core.req_wr      = r.wr;
    core.req_tag     = r.tag;
    core.req_cmo     = r.cmo;
    mem.mem_accept   = (int'($urandom_range(0, 99)) < acc_pct);
    mem.mem_ack      = (int'($urandom_range(0, 99)) < ((model_out > 0) ? ack_pct : spur_pct));
    mem.mem_error    = 1'($urandom_range(0, 1));
    mem.mem_data_rd  = $urandom;
    mem.mem_resp_tag = 11'($urandom);
    #2;
    check_output("req_accept", core.req_accept, (req_q.size() < DEPTH) ? 1 : 0);
    if (do_req && core.req_accept) begin
      r.born = cyc;
      req_q.push_back(r);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk_i);
    rst_ni         = 1'b0;
    core.req_rd    = 1'b0;
    core.req_wr    = 4'b0000;
    core.req_cmo   = 3'b000;
    mem.mem_accept = 1'b0;
    mem.mem_ack    = 1'b0;
    #2;
    check_output("rst_resp_ack",   core.resp_ack,   0);
    check_output("rst_resp_error", core.resp_error, 0);
    check_output("rst_resp_tag",   core.resp_tag,   0);
    check_output("rst_resp_data",  core.resp_data,  0);
    check_output("rst_mem_rd",     mem.mem_rd,      0);
    check_output("rst_mem_wr",     mem.mem_wr,      0);
    check_output("rst_mem_cmo",    mem.mem_cmo,     0);
    check_output("rst_mem_addr",   mem.mem_addr,    0);
    repeat (cycles) @(negedge clk_i);
    rst_ni = 1'b1;
    #2;
    check_output("rst_req_accept", core.req_accept, 1);
  endtask

  // Monitor: compares the DUT against the queue model every cycle, 3ns after the falling edge.
  initial begin : monitor
    logic        exp_ack;
    logic        exp_err;
    logic [10:0] exp_tag;
    logic [31:0] exp_data;
    logic        head_ok;
    logic        issue_ok;
    logic        pop;
    logic        valid;
    exp_ack  = 1'b0;
    exp_err  = 1'b0;
    exp_tag  = '0;
    exp_data = '0;
    forever begin
      @(negedge clk_i);
      #3;
      if (!rst_ni) begin
        req_q.delete();
        model_out = 0;
        exp_ack   = 1'b0;
        continue;
      end
      check_output("resp_ack", core.resp_ack, exp_ack);
      if (exp_ack) begin
        check_output("resp_data",  core.resp_data,  exp_data);
        check_output("resp_error", core.resp_error, exp_err);
        check_output("resp_tag",   core.resp_tag,   exp_tag);
      end
      head_ok  = (req_q.size() > 0) && (req_q[0].born < cyc);
      issue_ok = head_ok && (model_out < MAX_OUT) && ((req_q[0].cmo == 3'b000) || (model_out == 0));
      if (head_ok) begin
        check_output("mem_addr",    mem.mem_addr,    req_q[0].addr);
        check_output("mem_data_wr", mem.mem_data_wr, req_q[0].data);
        check_output("mem_tag",     mem.mem_tag,     req_q[0].tag);
      end
      check_output("mem_rd",  mem.mem_rd,  issue_ok ? req_q[0].rd  : 1'b0);
      check_output("mem_wr",  mem.mem_wr,  issue_ok ? req_q[0].wr  : 4'b0000);
      check_output("mem_cmo", mem.mem_cmo, issue_ok ? req_q[0].cmo : 3'b000);
      pop = issue_ok && mem.mem_accept;
      if (pop) void'(req_q.pop_front());
      valid   = mem.mem_ack && ((model_out > 0) || pop);
      exp_ack = valid;
      exp_err = mem.mem_error;
      exp_tag = mem.mem_resp_tag;
      if (valid) exp_data = mem.mem_data_rd;
      if (pop && !valid)      model_out++;
      else if (valid && !pop) model_out--;
    end
  end

  initial begin : driver
    core.req_addr    = '0;
    core.req_data_wr = '0;
    core.req_rd      = 1'b0;
    core.req_wr      = '0;
    core.req_tag     = '0;
    core.req_cmo     = '0;
    mem.mem_accept   = 1'b0;
    mem.mem_data_rd  = '0;
    mem.mem_ack      = 1'b0;
    mem.mem_error    = 1'b0;
    mem.mem_resp_tag = '0;
    $display("[TB] start");
    do_reset(3);

    // Eager slave, slow acks: keeps the outstanding cap and CMO drain busy.
    repeat (300) apply_stimulus($urandom_range(0, 99) < 70, 100, 15, 15, 3);
    // Balanced traffic with frequent spurious acks.
    repeat (300) apply_stimulus($urandom_range(0, 99) < 50, 50, 50, 20, 10);
    // Back-pressured slave so the FIFO sits full.
    repeat (200) apply_stimulus(1'b1, 20, 60, 10, 5);

    // Build 3 outstanding plus a full FIFO, then reset in the middle of it.
    for (int i = 0; i < 60 && model_out < 3; i++) apply_stimulus(1'b1, 100, 0, 0, 0);
    for (int i = 0; i < 60 && req_q.size() < DEPTH; i++) apply_stimulus(1'b1, 0, 0, 0, 0);
    do_reset(2);
    // Late acks for pre-reset requests must not reach the core.
    repeat (4) apply_stimulus(1'b0, 0, 0, 0, 100);

    repeat (300) apply_stimulus($urandom_range(0, 99) < 60, 70, 40, 15, 5);

    // Drain everything with a bounded wait.
    for (int i = 0; i < 300 && (req_q.size() > 0 || model_out > 0); i++)
      apply_stimulus(1'b0, 100, 100, 0, 0);
    repeat (2) apply_stimulus(1'b0, 100, 0, 0, 0);
    check_output("drain_left", 32'(req_q.size() + model_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
